// File: rtl/instr_encoder_loader_pkg.sv
// Shared RV32I encoding constants: op codes, opcodes, funct fields and loader FSM states.
// Control-unit decode uses the same constants, so they live here.
package rv_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_SRA  = 4'd5,
    OP_SLL  = 4'd6,
    OP_ADDI = 4'd7,
    OP_SLLI = 4'd8,
    OP_LW   = 4'd9,
    OP_SW   = 4'd10,
    OP_BEQ  = 4'd11,
    OP_BNE  = 4'd12,
    OP_BLT  = 4'd13,
    OP_BGE  = 4'd14,
    OP_RSVD = 4'd15
  } op_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRA  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Op-request and instruction-memory write bus of the loader.
// Both sides use valid/ready: a transfer happens on a rising edge where valid (in_valid / mem_we) and ready (in_ready / mem_ready) are both high; the sender holds its payload stable until then.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  // master: the loader (accepts ops, drives memory writes)
  modport master (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // slave: the host/memory environment
  modport slave (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader_enc.sv
// Pure combinational RV32I encoder: {op,rd,rs1,rs2,imm} -> {word,bad}.
// bad flags the reserved op and branches with an odd offset.
module rv_instr_enc
  import rv_enc_pkg::*;
(
  input  op_t         op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        bad
);
  always_comb begin
    word = 32'd0;
    bad  = 1'b0;
    case (op)
      OP_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_R};
      OP_SUB:  word = {F7_ALT,  rs2, rs1, F3_ADD, rd, OPC_R};
      OP_XOR:  word = {F7_BASE, rs2, rs1, F3_XOR, rd, OPC_R};
      OP_OR:   word = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_R};
      OP_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_R};
      OP_SRA:  word = {F7_ALT,  rs2, rs1, F3_SRA, rd, OPC_R};
      OP_SLL:  word = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_R};
      OP_ADDI: word = {imm[11:0], rs1, F3_ADD, rd, OPC_I};
      OP_SLLI: word = {7'b0, imm[4:0], rs1, F3_SLL, rd, OPC_I};
      OP_LW:   word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
      OP_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        word = {imm[12], imm[10:5], rs2, rs1,
                (op == OP_BEQ) ? F3_BEQ : (op == OP_BNE) ? F3_BNE :
                (op == OP_BLT) ? F3_BLT : F3_BGE,
                imm[4:1], imm[11], OPC_BRANCH};
        // branch offsets are in halfwords; bit 0 cannot be encoded
        bad  = imm[0];
      end
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Session loader: encodes accepted ops, buffers them in a small FIFO and streams
// them to instruction memory at consecutive word addresses.
module instr_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encoder_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           count,
  output state_t                state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t            state, state_n;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic              fifo_empty, fifo_full, full_n;
  logic              accept, push, pop;
  logic [31:0]       enc_word;
  logic              enc_bad;

  rv_instr_enc u_enc (
    .op   (op_t'(bus.in_op)),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .imm  (bus.in_imm),
    .word (enc_word),
    .bad  (enc_bad)
  );

  // Extra wrap bit on the pointers distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accept     = bus.in_valid && in_ready_q;
  assign push       = accept && !enc_bad;
  assign pop        = !fifo_empty && bus.mem_ready;
  assign wr_ptr_n   = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_n   = rd_ptr + {{AW{1'b0}}, pop};
  assign full_n     = (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (accept && bus.in_last) state_n = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_q     <= '0;
      count      <= 16'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_n;
      // registered from the next-cycle full flag, so a pop on a full FIFO
      // only reopens the input one cycle later
      in_ready_q <= (state_n == ST_RUN) && !full_n;
      busy       <= (state_n == ST_RUN);
      done       <= (state == ST_DRAIN) && (state_n == ST_IDLE);
      err        <= accept && enc_bad;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      if (state == ST_IDLE && start) begin
        addr_q <= base_addr & ~ADDR_W'(3);
        count  <= 16'd0;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_W'(4);
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];
  assign state_dbg     = state;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: hand-encoded words, write scoreboard,
// stall, address wrap and mid-drain reset scenarios.
module tb_instr_encoder_loader;
  import rv_enc_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, err;
  logic [15:0] count;
  state_t      state_dbg;

  instr_encoder_loader_if #(.ADDR_W(32)) ifc ();

  instr_encoder_loader #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (ifc),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count),
    .state_dbg (state_dbg)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int wr_cnt   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_a[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted memory write must match the next expected entry
  always @(negedge clk) begin
    logic [31:0] ea, ew;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (ifc.mem_we && ifc.mem_ready) begin
      wr_cnt++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        ea = exp_a.pop_front();
        ew = exp_q.pop_front();
        check("wr_addr", ifc.mem_addr, ea);
        check("wr_data", ifc.mem_wdata, ew);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] w);
    exp_a.push_back(a);
    exp_q.push_back(w);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    logic ok, rdy;
    ifc.in_op = op; ifc.in_rd = rd; ifc.in_rs1 = rs1; ifc.in_rs2 = rs2;
    ifc.in_imm = imm; ifc.in_last = last; ifc.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rdy = ifc.in_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(ifc.in_ready), 32'd0);
    check({tag, "_mem_we"},    32'(ifc.mem_we), 32'd0);
    check({tag, "_mem_addr"},  ifc.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, ifc.mem_wdata, 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_done"},      32'(done), 32'd0);
    check({tag, "_err"},       32'(err), 32'd0);
    check({tag, "_count"},     32'(count), 32'd0);
    check({tag, "_state"},     32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    logic [31:0] stall_words [6];
    int d0, e0, w0, accepted;
    logic rdy, stable;

    stall_words[0] = 32'h00100093; stall_words[1] = 32'h00200093;
    stall_words[2] = 32'h00300093; stall_words[3] = 32'h00400093;
    stall_words[4] = 32'h00500093; stall_words[5] = 32'h00600093;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    ifc.in_valid = 1'b0; ifc.in_op = '0; ifc.in_rd = '0; ifc.in_rs1 = '0;
    ifc.in_rs2 = '0; ifc.in_imm = '0; ifc.in_last = 1'b0; ifc.mem_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick(2);
    rst = 1'b0;
    tick();

    // ADDI x1,x0,5 at a base with low bits set
    d0 = done_cnt;
    expect_wr(32'h100, 32'h00500093);
    do_start(32'h103);
    check("a_busy", 32'(busy), 32'd1);
    check("a_in_ready", 32'(ifc.in_ready), 32'd1);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    wait_done("a_done");
    tick(3);
    check("a_done_once", 32'(done_cnt - d0), 32'd1);
    check("a_count", 32'(count), 32'd1);
    check("a_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("a_busy_low", 32'(busy), 32'd0);

    // SUB x3,x1,x2 ; SW x2,8(x1)
    expect_wr(32'h200, 32'h402081B3);
    expect_wr(32'h204, 32'h0020A423);
    do_start(32'h200);
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    send(OP_SW,  5'd0, 5'd1, 5'd2, 13'd8, 1'b1);
    wait_done("b_done");
    check("b_count", 32'(count), 32'd2);

    // mixed encodings, a misaligned branch and a reserved op as the last one
    e0 = err_cnt;
    expect_wr(32'h300, 32'hFE208EE3);
    expect_wr(32'h304, 32'h007302B3);
    expect_wr(32'h308, 32'h403150B3);
    expect_wr(32'h30C, 32'h00329213);
    expect_wr(32'h310, 32'hFF812303);
    expect_wr(32'h314, 32'h0041C863);
    do_start(32'h300);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b0);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
    check("c_err_pulse", 32'(err), 32'd1);
    send(OP_ADD,  5'd5, 5'd6, 5'd7, 13'd0, 1'b0);
    check("c_err_clear", 32'(err), 32'd0);
    send(OP_SRA,  5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    send(OP_SLLI, 5'd4, 5'd5, 5'd0, 13'd3, 1'b0);
    send(OP_LW,   5'd6, 5'd2, 5'd0, 13'h1FF8, 1'b0);
    send(OP_BLT,  5'd0, 5'd3, 5'd4, 13'd16, 1'b0);
    send(OP_RSVD, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1);
    wait_done("c_done");
    check("c_count", 32'(count), 32'd6);
    check("c_err_cnt", 32'(err_cnt - e0), 32'd2);
    check("c_addr_after", ifc.mem_addr, 32'h318);

    // memory stalled: only FIFO_DEPTH ops get in, head held stable
    ifc.mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) expect_wr(32'h400 + 32'(4 * k), stall_words[k]);
    w0 = wr_cnt;
    do_start(32'h400);
    accepted = 0;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ifc.in_op = OP_ADDI; ifc.in_rd = 5'd1; ifc.in_rs1 = 5'd0; ifc.in_rs2 = 5'd0;
      ifc.in_imm = 13'(accepted + 1); ifc.in_last = (accepted == 5);
      ifc.in_valid = 1'b1;
      rdy = ifc.in_ready;
      tick();
      if (rdy) accepted++;
      if (ifc.mem_we && (ifc.mem_addr !== 32'h400 || ifc.mem_wdata !== 32'h00100093))
        stable = 1'b0;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    check("s_accepted", 32'(accepted), 32'd4);
    check("s_in_ready", 32'(ifc.in_ready), 32'd0);
    check("s_mem_we", 32'(ifc.mem_we), 32'd1);
    check("s_stable", 32'(stable), 32'd1);
    check("s_no_writes", 32'(wr_cnt - w0), 32'd0);
    ifc.mem_ready = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd6, 1'b1);
    wait_done("s_done");
    check("s_count", 32'(count), 32'd6);

    // address wraps past the top of the space
    expect_wr(32'hFFFFFFFC, 32'h00700093);
    expect_wr(32'h00000000, 32'h00800093);
    do_start(32'hFFFFFFFC);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd7, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd8, 1'b1);
    wait_done("w_done");
    check("w_count", 32'(count), 32'd2);
    check("w_addr_after", ifc.mem_addr, 32'h4);

    // reset while draining three buffered words
    ifc.mem_ready = 1'b0;
    do_start(32'h500);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd1, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd2, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd3, 1'b1);
    check("r_drain", 32'(state_dbg), 32'(ST_DRAIN));
    check("r_mem_we", 32'(ifc.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("r_async");
    w0 = wr_cnt;
    ifc.mem_ready = 1'b1;
    tick(3);
    check("r_no_writes", 32'(wr_cnt - w0), 32'd0);
    rst = 1'b0;
    tick();
    expect_wr(32'h600, 32'h00500093);
    do_start(32'h600);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
    wait_done("r_done");
    check("r_count", 32'(count), 32'd1);

    tick(2);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
